// File: rtl/seq_bit_serializer_if.sv
// Parallel-word input and serial-bit output handshakes of the bit serializer.
interface seq_bit_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_ready;

  modport master (
    output in_data, in_valid, bit_ready,
    input  in_ready, bit_out, bit_valid
  );

  modport slave (
    input  in_data, in_valid, bit_ready,
    output in_ready, bit_out, bit_valid
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// Buffers parallel words in a small FIFO and emits them as a gapless serial
// bit stream, one bit per accepted cycle.
module seq_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  seq_bit_serializer_if.slave    bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, shifted;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, empty, push, pop, last_bit;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push     = bus.in_valid && !full;
  assign last_bit = (bit_cnt_q == '0);

  // Outputs are pure decodes of registered state.
  assign bus.in_ready  = !full;
  assign bus.bit_valid = (state_q == SHIFT);
  assign bus.bit_out   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign busy          = (state_q == SHIFT) || !empty;
  assign fifo_count    = count_q;

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  // Next-state, shifter and pop decision.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    pop       = 1'b0;
    shifted   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shreg_d   = mem_q[rd_ptr_q];
          bit_cnt_d = BW'(WIDTH - 1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.bit_ready) begin
          if (!last_bit) begin
            shreg_d   = shifted;
            bit_cnt_d = bit_cnt_q - BW'(1);
          end else if (!empty) begin
            // Reload straight from the FIFO so consecutive words have no bubble.
            pop       = 1'b1;
            shreg_d   = mem_q[rd_ptr_q];
            bit_cnt_d = BW'(WIDTH - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy update; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer (WIDTH=8, DEPTH=4, MSB first).
module tb_seq_bit_serializer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_count;
  int                     passed = 0;
  int                     total  = 0;

  seq_bit_serializer_if #(.WIDTH(WIDTH)) bus ();

  seq_bit_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h3C;
    bus.bit_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else passed++;
    total++; if (bus.bit_valid !== 1'b0) $display("FAIL reset_bit_valid: got %b want 0", bus.bit_valid); else passed++;
    total++; if (bus.bit_out !== 1'b0) $display("FAIL reset_bit_out: got %b want 0", bus.bit_out); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (fifo_count !== 3'd0) $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); else passed++;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (fifo_count !== 3'd0) $display("FAIL reset_nothing_accepted: got %0d want 0", fifo_count); else passed++;
    total++; if (bus.bit_valid !== 1'b0) $display("FAIL reset_no_bits: got %b want 0", bus.bit_valid); else passed++;
  endtask

  task automatic test_single();
    logic [7:0] w;
    w = 8'hA5;
    @(posedge clk); #1;
    bus.bit_ready = 1'b1;
    bus.in_data   = w;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    total++; if (bus.bit_valid !== 1'b0) $display("FAIL single_latency: bit_valid got %b want 0", bus.bit_valid); else passed++;
    total++; if (fifo_count !== 3'd1) $display("FAIL single_count: got %0d want 1", fifo_count); else passed++;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      total++; if (bus.bit_valid !== 1'b1) $display("FAIL single_valid[%0d]: got %b want 1", i, bus.bit_valid); else passed++;
      total++; if (bus.bit_out !== w[7-i]) $display("FAIL single_bit[%0d]: got %b want %b", i, bus.bit_out, w[7-i]); else passed++;
      @(posedge clk); #1;
    end
    total++; if (bus.bit_valid !== 1'b0) $display("FAIL single_end_valid: got %b want 0", bus.bit_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL single_end_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream;
    logic [15:0] hits;
    logic [3:0]  win;
    stream = '0;
    hits   = '0;
    win    = '0;
    @(posedge clk); #1;
    bus.bit_ready = 1'b1;
    bus.in_data   = 8'h0A;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_data = 8'hA0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.bit_valid !== 1'b1) $display("FAIL b2b_gap[%0d]: bit_valid got %b want 1", i, bus.bit_valid); else passed++;
      stream = {stream[14:0], bus.bit_out};
      win    = {win[2:0], bus.bit_out};
      if (i >= 3 && win == 4'b1010) hits[i] = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (stream !== 16'h0AA0) $display("FAIL b2b_stream: got %h want 0aa0", stream); else passed++;
    total++; if (hits !== 16'h0A80) $display("FAIL b2b_detect: got %h want 0a80", hits); else passed++;
    total++; if (bus.bit_valid !== 1'b0) $display("FAIL b2b_end_valid: got %b want 0", bus.bit_valid); else passed++;
  endtask

  task automatic test_full();
    logic [7:0] w [6];
    logic [7:0] rx;
    logic       acc;
    logic       accepted;
    w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    rx = '0;
    accepted = 1'b0;
    @(posedge clk); #1;
    bus.bit_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.in_data  = w[k];
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_data = w[5];
    total++; if (fifo_count !== 3'd4) $display("FAIL full_count: got %0d want 4", fifo_count); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL full_in_ready: got %b want 0", bus.in_ready); else passed++;
    total++; if (bus.bit_valid !== 1'b1) $display("FAIL full_shifter_loaded: got %b want 1", bus.bit_valid); else passed++;
    repeat (2) begin
      @(posedge clk); #1;
      total++; if (fifo_count !== 3'd4) $display("FAIL full_held_count: got %0d want 4", fifo_count); else passed++;
      total++; if (bus.in_ready !== 1'b0) $display("FAIL full_held_ready: got %b want 0", bus.in_ready); else passed++;
      total++; if (bus.bit_out !== w[0][7]) $display("FAIL full_stall_bit: got %b want %b", bus.bit_out, w[0][7]); else passed++;
    end
    bus.bit_ready = 1'b1;
    for (int n = 0; n < 48; n++) begin
      total++; if (bus.bit_valid !== 1'b1) $display("FAIL full_drain_valid[%0d]: got %b want 1", n, bus.bit_valid); else passed++;
      rx  = {rx[6:0], bus.bit_out};
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        bus.in_valid = 1'b0;
        accepted     = 1'b1;
      end
      if (n % 8 == 7) begin
        total++; if (rx !== w[n/8]) $display("FAIL full_order[%0d]: got %h want %h", n/8, rx, w[n/8]); else passed++;
      end
    end
    total++; if (accepted !== 1'b1) $display("FAIL full_held_word_accepted: got %b want 1", accepted); else passed++;
    total++; if (bus.bit_valid !== 1'b0) $display("FAIL full_end_valid: got %b want 0", bus.bit_valid); else passed++;
  endtask

  task automatic test_stall();
    logic [7:0] w;
    logic [7:0] rx;
    w  = 8'hC3;
    rx = '0;
    @(posedge clk); #1;
    bus.bit_ready = 1'b1;
    bus.in_data   = w;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      total++; if (bus.bit_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", i, bus.bit_valid); else passed++;
      if (i == 3) begin
        bus.bit_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          total++; if (bus.bit_out !== w[7-i]) $display("FAIL stall_hold: got %b want %b", bus.bit_out, w[7-i]); else passed++;
        end
        bus.bit_ready = 1'b1;
      end
      rx = {rx[6:0], bus.bit_out};
      @(posedge clk); #1;
    end
    total++; if (rx !== w) $display("FAIL stall_word: got %h want %h", rx, w); else passed++;
    total++; if (bus.bit_valid !== 1'b0) $display("FAIL stall_end_valid: got %b want 0", bus.bit_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    w = 8'h5A;
    @(posedge clk); #1;
    bus.bit_ready = 1'b1;
    bus.in_data   = 8'hFF;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_data = 8'h81;
    @(posedge clk); #1;
    bus.in_data = 8'h7E;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    total++; if (fifo_count !== 3'd2) $display("FAIL rmid_queued: got %0d want 2", fifo_count); else passed++;
    total++; if (bus.bit_out !== 1'b1) $display("FAIL rmid_pre_bit: got %b want 1", bus.bit_out); else passed++;
    #2;
    reset = 1'b0;
    #1;
    total++; if (bus.bit_valid !== 1'b0) $display("FAIL rmid_bit_valid: got %b want 0", bus.bit_valid); else passed++;
    total++; if (bus.bit_out !== 1'b0) $display("FAIL rmid_bit_out: got %b want 0", bus.bit_out); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else passed++;
    total++; if (fifo_count !== 3'd0) $display("FAIL rmid_count: got %0d want 0", fifo_count); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL rmid_in_ready: got %b want 1", bus.in_ready); else passed++;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      total++; if (bus.bit_valid !== 1'b0) $display("FAIL rmid_stale_bit: got %b want 0", bus.bit_valid); else passed++;
    end
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      total++; if (bus.bit_out !== w[7-i] || bus.bit_valid !== 1'b1)
        $display("FAIL rmid_fresh_bit[%0d]: got %b/%b want %b/1", i, bus.bit_out, bus.bit_valid, w[7-i]);
      else passed++;
      @(posedge clk); #1;
    end
    total++; if (bus.bit_valid !== 1'b0) $display("FAIL rmid_end_valid: got %b want 0", bus.bit_valid); else passed++;
  endtask

  initial begin
    reset         = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.bit_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_bit_serializer.md
# seq_bit_serializer

Upstream stimulus stage for the 1010 sequence detector. It accepts parallel words over a valid/ready handshake, buffers them in a small FIFO, and emits them one bit per accepted cycle as a serial stream (bit_out/bit_valid/bit_ready) that drives the detector's serial input. Words are sent back-to-back with no idle bubble while the FIFO holds data.

## Interface
Parameters:
- WIDTH, 8: bits per input word; must be ≥ 2.
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- MSB_FIRST, 1: 1 = shift MSB first; 0 = LSB first.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; reset = 0 clears all state immediately.
- in_data  in  WIDTH  word to serialize.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept a word; equals !full.
- bit_out  out  1  current serial bit.
- bit_valid  out  1  bit_out holds a real data bit.
- bit_ready  in  1  consumer takes bit_out this cycle; tie to 1 for a free-running detector.
- busy  out  1  high in SHIFT or when the FIFO is non-empty.
- fifo_count  out  $clog2(DEPTH)+1  number of buffered words, excluding the word in the shifter.

## Operation
- Push: when in_valid && in_ready at a clock edge, in_data is written at wr_ptr, wr_ptr increments, and count increments.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- full = (count == DEPTH); empty = (count == 0). Both come from the registered count.
- in_valid while full: the word is not accepted and the producer holds it. There is no push-through, even if a pop happens in the same cycle.
- FSM states:
  - IDLE: bit_valid = 0. If !empty, pop the head into shreg, set bit_cnt = WIDTH-1, and go to SHIFT.
  - SHIFT: bit_valid = 1. bit_out = shreg[WIDTH-1] when MSB_FIRST = 1, else shreg[0].
    - bit_ready = 0: hold all state and keep bit_out stable.
    - bit_ready = 1 and bit_cnt != 0: shift shreg toward the output end and decrement bit_cnt.
    - bit_ready = 1, bit_cnt == 0, !empty: pop the next word into shreg, reload bit_cnt = WIDTH-1, and stay in SHIFT. This gives zero bubble between words.
    - bit_ready = 1, bit_cnt == 0, empty: go to IDLE.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Push into an empty FIFO: the pop cannot happen in the same cycle. The word is visible to IDLE on the next cycle.
- Reset values (asynchronous, reset = 0): state = IDLE, wr_ptr = rd_ptr = 0, count = 0, shreg = 0, bit_cnt = 0.
  - Resulting outputs: in_ready = 1, bit_out = 0, bit_valid = 0, busy = 0, fifo_count = 0.
- Reset mid-word: the partial word and all buffered words are discarded. No further bits are emitted until new words are pushed after reset deasserts.

## Timing
- Latency: a word accepted at edge k into an empty FIFO, with the FSM in IDLE, is popped at edge k+1. Its first bit is valid after edge k+1.
- A word occupies exactly WIDTH bit_valid&&bit_ready cycles.
- Throughput: 1 bit/cycle with bit_ready = 1 and the FIFO kept non-empty.
- in_ready deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the next pop.
- bit_out and bit_valid are registered state decodes. No combinational path exists from bit_ready or in_valid to any output.
- Reset deassertion is used directly and is not synchronized inside this block. The integrator provides a synchronized deassert.

## Test plan
- Reset: hold reset = 0 for 2 cycles while driving in_valid = 1 → in_ready = 1, bit_valid = 0, fifo_count = 0, and nothing is accepted.
- Single word: WIDTH = 8, MSB_FIRST = 1, push 8'hA5 with bit_ready = 1 → bit_valid rises 1 cycle after the accept edge. bit_out = 1,0,1,0,0,1,0,1 over 8 cycles, then bit_valid = 0 and busy = 0.
- Back-to-back: push 8'h0A then 8'hA0 on consecutive cycles → 16 contiguous valid bits 0000_1010_1010_0000 with no gap. The detector downstream flags 1010 at the expected cycles.
- Full/backpressure: bit_ready = 0, push 5 words → the first word enters the shifter. The next 4 fill the FIFO: fifo_count = 4, in_ready = 0, and a 6th word is held. Raising bit_ready drains all words in push order.
- Stall mid-word: push 8'hC3 and drop bit_ready for 3 cycles after bit 2 → bit_out is held stable during the stall. The full sequence 1100_0011 arrives with no lost or duplicated bits.
- Reset mid-operation: assert reset after bit 4 of 8'hFF with 2 words queued → outputs return to reset values immediately. After release, no stale bits appear and a fresh 8'h5A serializes correctly.
